// File: rtl/input_pkg.sv
// Shared definitions for the player push-button front end.
// Holds the channel state encoding, button bit positions and the timing profiles.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_e;

    localparam int X_UP   = 0;
    localparam int X_DOWN = 1;
    localparam int Y_UP   = 2;
    localparam int Y_DOWN = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Short profile so simulations see presses and repeats within a few dozen cycles.
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 8;
    localparam int SIM_REPEAT_PERIOD   = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button lane: two-flop synchroniser, debouncer and press/auto-repeat FSM.
// state  | meaning
// IDLE   | button released, waiting for a debounced press
// HOLD   | press strobe sent, counting down to the first repeat
// REPEAT | auto-repeating every REPEAT_PERIOD cycles while held
module button_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic move_n,
    output logic btn_level
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_HOLD   = HOLD;
    localparam logic [1:0] S_REPEAT = REPEAT;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LD_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] LD_PERIOD = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;   // raw polarity: 1 = released
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    logic          move_n_q, move_n_d;
    logic          level_q;
    logic          strobe;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + ONE;
            end
        end
    end

    // Release has priority over any repeat due in the same cycle.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        strobe    = 1'b0;
        if (stable_q) begin
            state_d   = S_IDLE;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_HOLD;
                    rep_cnt_d = LD_DELAY;
                    strobe    = 1'b1;
                end
                S_HOLD: begin
                    if (rep_cnt_q == ONE) begin
                        state_d   = S_REPEAT;
                        rep_cnt_d = LD_PERIOD;
                        strobe    = 1'b1;
                    end else if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - ONE;
                    end
                end
                S_REPEAT: begin
                    if (rep_cnt_q == ONE) begin
                        rep_cnt_d = LD_PERIOD;
                        strobe    = 1'b1;
                    end else if (rep_cnt_q != '0) begin
                        rep_cnt_d = rep_cnt_q - ONE;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end
        move_n_d = ~strobe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            stable_q  <= 1'b1;
            db_cnt_q  <= '0;
            state_q   <= S_IDLE;
            rep_cnt_q <= '0;
            move_n_q  <= 1'b1;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            move_n_q  <= move_n_d;
            level_q   <= ~stable_q;
        end
    end

    assign move_n    = move_n_q;
    assign btn_level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent button lanes producing active-low cursor move strobes.
// No arbitration: opposing directions may strobe together, the cursor resolves them.
module button_conditioner
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic [3:0] move_n,
    output logic [3:0] btn_level
);

    for (genvar g = 0; g < 4; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_n    (btn_n[g]),
            .move_n   (move_n[g]),
            .btn_level(btn_level[g])
        );
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage that turns the four raw, bouncing, active-low player push-buttons into clean single-cycle active-low move strobes for the player cursor register. Each button is synchronised, debounced, edge-detected and optionally auto-repeated while held. Outputs connect directly to the cursor's x-up / x-down / y-up / y-down inputs. The cursor advances exactly one step per strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept a level change; must be ≥1.
- `REPEAT_DELAY`, default 25000000: cycles from the press strobe to the first repeat strobe; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent repeat strobes; must be ≥1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_n`  in  4  raw buttons, active-low, asynchronous. Bit 0 is x_up, bit 1 is x_down, bit 2 is y_up, bit 3 is y_down.
- `move_n`  out  4  registered move strobes, active-low, one cycle low per event; same bit order.
- `btn_level`  out  4  debounced level, active-high (1 = held); for status LEDs.

## Operation
- All four channels are identical and independent. There is no arbitration: opposing buttons may strobe in the same cycle, and the downstream cursor resolves them.
- **Synchroniser:** two flops per bit; both reset to 1 (released).
- **Debouncer:**
  - A `stable` bit resets to released, and a counter resets to 0.
  - When the synchronised value equals `stable`, the counter clears.
  - When it differs, the counter increments.
  - When it differs and the counter equals `DEBOUNCE_CYCLES-1`, `stable` takes the synchronised value and the counter clears.
  - Any single matching cycle restarts the count.
- **Per-channel FSM**, states IDLE, HOLD, REPEAT:
  - IDLE → HOLD on a `stable` released→pressed transition. Emit a strobe and load the repeat counter with `REPEAT_DELAY`.
  - HOLD: the counter decrements each cycle. When it reaches 1, emit a strobe, load `REPEAT_PERIOD`, and go to REPEAT. If `REPEAT_DELAY`=0, stay in HOLD with no further strobes.
  - REPEAT: the counter decrements each cycle. On reaching 1, emit a strobe and reload `REPEAT_PERIOD`.
  - Any state → IDLE when `stable` returns to released. No strobe is emitted on release. A release in the same cycle a repeat would fire wins, so no strobe is emitted.
- Counter widths: `$clog2` of the largest of the three parameters, plus 1. There is no wrap; counters saturate by construction.
- **Reset:**
  - Outputs: `move_n`=4'b1111 and `btn_level`=4'b0000.
  - Internal state: FSMs in IDLE and all counters at 0.
  - A reset asserted mid-hold aborts any pending repeat.
  - A button held through reset is treated as a fresh press after reset deasserts, and produces exactly one press strobe.

## Timing
- Strobe latency: the raw edge is sampled at edge 0, is synchronised by edge 1, and `stable` flips at edge 1+`DEBOUNCE_CYCLES`. `move_n` is low during the cycle after edge 2+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+3 edges including edge 0.
- `btn_level` follows `stable` through one register and aligns with the press strobe.
- Repeat schedule, with the press strobe at cycle P:
  - first repeat at P+`REPEAT_DELAY`;
  - then P+`REPEAT_DELAY`+n·`REPEAT_PERIOD`.
- The strobe is exactly one cycle wide, and `move_n` is never low in two consecutive cycles when `REPEAT_PERIOD`≥2.
- Release latency to `btn_level`=0 is the same `DEBOUNCE_CYCLES`+3 edges.

## Structure
- Shared package `input_pkg`:
  - channel state enum (IDLE/HOLD/REPEAT);
  - button bit-index constants (X_UP=0, X_DOWN=1, Y_UP=2, Y_DOWN=3);
  - default timing constants;
  - a sim-profile set (debounce 4, delay 8, period 3).
- Sub-module `button_channel`: synchroniser, debouncer and FSM for one bit. The top instantiates four copies via generate and concatenates the outputs.

## Test plan
All scenarios use the sim profile (`DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3).
- **Reset values:** assert `rst` for 3 cycles with `btn_n`=4'b1111 → `move_n`=4'b1111 and `btn_level`=0 throughout and after.
- **Clean press:** drive `btn_n[0]` low at edge 0 and hold for 6 cycles, then release → `move_n[0]` low only in the cycle after edge 6, `btn_level[0]` rises at edge 6, no repeat, no strobe on release.
- **Bounce rejection:** toggle `btn_n[1]` low/high every 2 cycles for 20 cycles, then hold high → `move_n[1]` never low and `btn_level[1]` stays 0.
- **Auto-repeat:** hold `btn_n[2]` low for 30 cycles → strobes at cycles P, P+8, P+11, P+14…, with no strobe after release is debounced.
- **Simultaneous opposing buttons:** press `btn_n[0]` and `btn_n[1]` together → both `move_n` bits low in the same cycle.
- **Reset mid-hold:** hold `btn_n[3]` low, assert `rst` at P+5 for 2 cycles while still held → no repeat at P+8. Exactly one new press strobe follows, 7 edges after `rst` deasserts.
